// File: rtl/axi_grid_rr_merge.sv
// Round-robin merge of NUM_IN grid request streams onto one registered output link.
// A grant is locked to one input from its first beat until its last beat.
module axi_grid_rr_merge #(
    parameter type grid_id_t = logic [7:0],
    parameter type chan_t    = logic [31:0],
    parameter int  NUM_IN    = 3
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  grid_id_t          did_i   [NUM_IN],
    input  grid_id_t          sid_i   [NUM_IN],
    input  chan_t             chan_i  [NUM_IN],
    input  logic [NUM_IN-1:0] last_i,
    input  logic [NUM_IN-1:0] valid_i,
    output logic [NUM_IN-1:0] ready_o,
    output grid_id_t          did_o,
    output grid_id_t          sid_o,
    output chan_t             chan_o,
    output logic              last_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              dbg_lock_o
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_lock_idx;
    logic               r_valid;
    grid_id_t           r_did;
    grid_id_t           r_sid;
    chan_t              r_chan;
    logic               r_last;

    logic               w_slot_free;
    logic               w_win_vld;
    logic [IDX_W-1:0]   w_win_idx;
    logic [IDX_W-1:0]   w_cand;
    logic [IDX_W-1:0]   w_next_ptr;
    logic               w_xfer;

    // Handshake: a beat moves on any link in a cycle where valid and ready are both high;
    // the output slot may take a new beat when it is empty or being drained this cycle.
    assign w_slot_free = !r_valid || ready_i;

    // Scan offsets from highest to lowest so the closest valid input to rr_ptr wins.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
        if (r_state == S_LOCK) begin
            w_win_vld = 1'b1;
            w_win_idx = r_lock_idx;
        end else begin
            for (int off = NUM_IN - 1; off >= 0; off--) begin
                w_cand = IDX_W'((int'(r_rr_ptr) + off) % NUM_IN);
                if (valid_i[w_cand]) begin
                    w_win_vld = 1'b1;
                    w_win_idx = w_cand;
                end
            end
        end
    end

    always_comb begin
        ready_o = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            ready_o[k] = !srst_i && w_slot_free && w_win_vld && (w_win_idx == IDX_W'(k));
        end
    end

    assign w_xfer     = !srst_i && w_slot_free && w_win_vld && valid_i[w_win_idx];
    assign w_next_ptr = (w_win_idx == IDX_W'(NUM_IN - 1)) ? '0 : w_win_idx + 1'b1;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
            r_valid    <= 1'b0;
            r_did      <= '0;
            r_sid      <= '0;
            r_chan     <= '0;
            r_last     <= 1'b0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_did   <= did_i[w_win_idx];
            r_sid   <= sid_i[w_win_idx];
            r_chan  <= chan_i[w_win_idx];
            r_last  <= last_i[w_win_idx];
            case (r_state)
                S_IDLE: begin
                    if (last_i[w_win_idx]) begin
                        r_rr_ptr <= w_next_ptr;
                    end else begin
                        r_state    <= S_LOCK;
                        r_lock_idx <= w_win_idx;
                    end
                end
                S_LOCK: begin
                    if (last_i[w_win_idx]) begin
                        r_state  <= S_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o    = r_valid;
    assign did_o      = r_did;
    assign sid_o      = r_sid;
    assign chan_o     = r_chan;
    assign last_o     = r_last;
    assign dbg_lock_o = (r_state == S_LOCK);

endmodule

// File: tb/tb_axi_grid_rr_merge.sv
// Bench for axi_grid_rr_merge: table-driven corner sequences plus randomized traffic,
// both checked against a cycle-level reference model and an expected-payload queue.
module tb_axi_grid_rr_merge;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          srst_i;
    logic [7:0]    did_i  [N];
    logic [7:0]    sid_i  [N];
    logic [15:0]   chan_i [N];
    logic [N-1:0]  last_i;
    logic [N-1:0]  valid_i;
    logic [N-1:0]  ready_o;
    logic [7:0]    did_o;
    logic [7:0]    sid_o;
    logic [15:0]   chan_o;
    logic          last_o;
    logic          valid_o;
    logic          ready_i;
    logic          dbg_lock_o;

    axi_grid_rr_merge #(
        .grid_id_t (logic [7:0]),
        .chan_t    (logic [15:0]),
        .NUM_IN    (N)
    ) dut (
        .clk_i      (clk),
        .srst_i     (srst_i),
        .did_i      (did_i),
        .sid_i      (sid_i),
        .chan_i     (chan_i),
        .last_i     (last_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .did_o      (did_o),
        .sid_o      (sid_o),
        .chan_o     (chan_o),
        .last_o     (last_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .dbg_lock_o (dbg_lock_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: which input owns the link, where the rotation resumes, and the
    // beat that should currently sit on the output.
    logic        m_lock;
    int          m_owner;
    int          m_rr;
    logic        m_ov;
    logic [7:0]  m_did;
    logic [7:0]  m_sid;
    logic [15:0] m_chan;
    logic        m_last;
    logic [7:0]  seq [N];
    logic [15:0] exp_q [$];

    typedef struct {
        logic       rst;
        logic [2:0] vld;
        logic [2:0] lst;
        logic       rdy;
        logic [2:0] e_rdy;
        logic       e_vld;
        logic [7:0] e_sid;
    } vec_t;

    vec_t tab [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lock  = 1'b0;
        m_owner = 0;
        m_rr    = 0;
        m_ov    = 1'b0;
        m_did   = '0;
        m_sid   = '0;
        m_chan  = '0;
        m_last  = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle: drive, check against the model (and optional hand expectations), advance.
    task automatic cycle(input logic rst, input logic [2:0] v, input logic [2:0] l, input logic r,
                         input logic tab_chk, input logic [2:0] e_rdy, input logic e_vld,
                         input logic [7:0] e_sid);
        int          win;
        logic        free;
        logic        xfer;
        logic [2:0]  want_rdy;
        @(negedge clk);
        srst_i  = rst;
        valid_i = v;
        last_i  = l;
        ready_i = r;
        for (int k = 0; k < N; k++) begin
            did_i[k]  = 8'hD0 + 8'(k);
            sid_i[k]  = 8'(k);
            chan_i[k] = {8'(k), seq[k]};
        end
        #1;
        free = !m_ov || r;
        win  = -1;
        if (!rst) begin
            if (m_lock) win = m_owner;
            else begin
                for (int off = 0; off < N; off++) begin
                    if (win < 0 && v[(m_rr + off) % N]) win = (m_rr + off) % N;
                end
            end
        end
        want_rdy = (win >= 0 && free) ? 3'(1 << win) : 3'b000;
        xfer     = (win >= 0) && free && v[win];

        check("ready_o", 32'(ready_o), 32'(want_rdy));
        check("valid_o", 32'(valid_o), 32'(m_ov));
        check("dbg_lock", 32'(dbg_lock_o), 32'(m_lock));
        if (m_ov) begin
            check("did_o", 32'(did_o), 32'(m_did));
            check("sid_o", 32'(sid_o), 32'(m_sid));
            check("chan_o", 32'(chan_o), 32'(m_chan));
            check("last_o", 32'(last_o), 32'(m_last));
        end
        if (!rst && m_ov && r) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'(1), 32'(0));
            else check("sb_chan", 32'(chan_o), 32'(exp_q.pop_front()));
        end
        if (tab_chk) begin
            check("tab_ready", 32'(ready_o), 32'(e_rdy));
            check("tab_valid", 32'(valid_o), 32'(e_vld));
            if (e_vld) check("tab_sid", 32'(sid_o), 32'(e_sid));
        end

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (xfer) begin
            m_ov   = 1'b1;
            m_did  = did_i[win];
            m_sid  = sid_i[win];
            m_chan = chan_i[win];
            m_last = l[win];
            exp_q.push_back(chan_i[win]);
            seq[win] = seq[win] + 8'd1;
            if (l[win]) begin
                m_lock = 1'b0;
                m_rr   = (win + 1) % N;
            end else begin
                m_lock  = 1'b1;
                m_owner = win;
            end
        end else if (r) begin
            m_ov = 1'b0;
        end
    endtask

    initial begin
        // rst vld lst rdy | e_rdy e_vld e_sid
        tab[0]  = '{1'b1, 3'b111, 3'b111, 1'b1, 3'b000, 1'b0, 8'd0};
        tab[1]  = '{1'b1, 3'b111, 3'b111, 1'b1, 3'b000, 1'b0, 8'd0};
        tab[2]  = '{1'b0, 3'b111, 3'b111, 1'b1, 3'b001, 1'b0, 8'd0};
        tab[3]  = '{1'b0, 3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 8'd0};
        tab[4]  = '{1'b0, 3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 8'd1};
        tab[5]  = '{1'b0, 3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 8'd2};
        tab[6]  = '{1'b0, 3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 8'd0};
        tab[7]  = '{1'b0, 3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 8'd1};
        tab[8]  = '{1'b0, 3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 8'd2};
        tab[9]  = '{1'b0, 3'b111, 3'b101, 1'b1, 3'b010, 1'b1, 8'd0};
        tab[10] = '{1'b0, 3'b111, 3'b101, 1'b1, 3'b010, 1'b1, 8'd1};
        tab[11] = '{1'b0, 3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 8'd1};
        tab[12] = '{1'b0, 3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 8'd1};
        tab[13] = '{1'b0, 3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 8'd2};
        tab[14] = '{1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 8'd0};
        tab[15] = '{1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 8'd0};
        tab[16] = '{1'b0, 3'b100, 3'b000, 1'b1, 3'b100, 1'b0, 8'd0};
        tab[17] = '{1'b0, 3'b001, 3'b001, 1'b1, 3'b100, 1'b1, 8'd2};
        tab[18] = '{1'b0, 3'b001, 3'b001, 1'b1, 3'b100, 1'b0, 8'd0};
        tab[19] = '{1'b0, 3'b001, 3'b001, 1'b1, 3'b100, 1'b0, 8'd0};
        tab[20] = '{1'b0, 3'b101, 3'b101, 1'b1, 3'b100, 1'b0, 8'd0};
        tab[21] = '{1'b0, 3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 8'd2};
        tab[22] = '{1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 8'd0};

        for (int k = 0; k < N; k++) begin
            seq[k]    = '0;
            did_i[k]  = '0;
            sid_i[k]  = '0;
            chan_i[k] = '0;
        end
        srst_i  = 1'b1;
        valid_i = '0;
        last_i  = '0;
        ready_i = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset hold, fairness, packet lock and bubble-in-lock sequences.
        for (int i = 0; i < 23; i++) begin
            cycle(tab[i].rst, tab[i].vld, tab[i].lst, tab[i].rdy,
                  1'b1, tab[i].e_rdy, tab[i].e_vld, tab[i].e_sid);
        end

        // Reset in the middle of a 4-beat packet from input 1.
        cycle(1'b0, 3'b010, 3'b000, 1'b1, 1'b1, 3'b010, 1'b0, 8'd0);
        cycle(1'b0, 3'b010, 3'b000, 1'b1, 1'b1, 3'b010, 1'b1, 8'd1);
        cycle(1'b1, 3'b111, 3'b000, 1'b1, 1'b1, 3'b000, 1'b1, 8'd1);
        cycle(1'b0, 3'b111, 3'b111, 1'b1, 1'b1, 3'b001, 1'b0, 8'd0);

        // Output backpressure for five cycles, then resume.
        cycle(1'b0, 3'b111, 3'b111, 1'b1, 1'b1, 3'b010, 1'b1, 8'd0);
        repeat (5) cycle(1'b0, 3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 1'b1, 8'd1);
        cycle(1'b0, 3'b111, 3'b111, 1'b1, 1'b1, 3'b100, 1'b1, 8'd1);
        cycle(1'b0, 3'b111, 3'b111, 1'b1, 1'b1, 3'b001, 1'b1, 8'd2);

        // Randomized traffic with multi-beat packets, stalls and rare resets.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 149) == 0),
                  3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0),
                  1'b0, 3'b000, 1'b0, 8'd0);
        end

        // Drain: every accepted beat must have left the output.
        repeat (4) cycle(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 8'd0);
        check("sb_drained", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
